pt2262_tx_scheduler: RTL

//   Shares one codificador_pt2262 encoder among N_REQ requesters. Round-robin arbitration

---
 rtl/pt2262_tx_scheduler_if.sv | 13 +
 rtl/pt2262_tx_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pt2262_tx_scheduler_if.sv
// Requester-side bus of the PT2262 scheduler: per-requester valid/payload in, one-hot ready back.
// Payload lanes are packed by requester index: address 16 bits/requester, data 4 bits/requester.
interface pt2262_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_addr;
  logic [4*N_REQ-1:0]  req_data;
  logic [N_REQ-1:0]    req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/pt2262_tx_scheduler.sv
// Round-robin scheduler sharing one PT2262 encoder; words change 1 clk after an enc_sync rise.
// req_ready is a same-cycle one-hot accept; a requester simply waits while a transfer is in flight.
module pt2262_tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int REPEAT  = 4,
  parameter int TIMEOUT = 262144
) (
  input  logic                     clk,
  input  logic                     reset,
  pt2262_tx_scheduler_if.slave     req_if,
  input  logic                     enc_sync_i,
  output wire  [7:0]               enc_A_o,
  output logic [3:0]               enc_D_o,
  output logic                     busy_o,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     done_o,
  output logic                     timeout_err_o
);
  localparam int GW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [15:0] IDLE_A = 16'hFFFF;

  logic [1:0]     state_q, state_d;
  logic           sync_q;
  logic           sync_rise;
  logic [15:0]    a_q, a_d, pay_a_q, pay_a_d;
  logic [3:0]     d_q, d_d, pay_d_q, pay_d_d;
  logic [GW-1:0]  gid_q, gid_d, ptr_q, ptr_d;
  logic [3:0]     rep_q, rep_d;
  logic [TW-1:0]  cnt_q, cnt_d;

  logic [2*N_REQ-1:0] valid_dbl;
  logic [N_REQ-1:0]   valid_rot;
  logic               win_vld;
  logic [GW-1:0]      win_idx;
  logic [15:0]        win_a;
  logic [3:0]         win_d;
  logic               grant, done_c, tmo_c;

  function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] v);
    return (v == GW'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  assign sync_rise = enc_sync_i & ~sync_q;

  // Rotate valids so bit 0 is the requester at rr pointer; lowest set bit wins.
  assign valid_dbl = {req_if.req_valid, req_if.req_valid};
  assign valid_rot = N_REQ'(valid_dbl >> ptr_q);

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_vld = 1'b1;
        win_idx = GW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign win_a = 16'(req_if.req_addr >> {win_idx, 4'd0});
  assign win_d = 4'(req_if.req_data >> {win_idx, 2'd0});

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    pay_a_d = pay_a_q;
    pay_d_d = pay_d_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    done_c  = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (win_vld) begin
          grant   = 1'b1;
          pay_a_d = win_a;
          pay_d_d = win_d;
          gid_d   = win_idx;
          ptr_d   = inc_mod(win_idx);
          state_d = S_WAIT;
        end
      end
      S_WAIT, S_SEND: begin
        if (sync_rise) begin
          cnt_d = '0;
          if (state_q == S_WAIT) begin
            a_d     = pay_a_q;
            d_d     = pay_d_q;
            rep_d   = '0;
            state_d = S_SEND;
          end else if (rep_q != 4'(REPEAT - 1)) begin
            rep_d = rep_q + 4'd1;
          end else begin
            done_c = 1'b1;
            rep_d  = '0;
            // Next winner goes straight onto the encoder at this boundary: no idle frame.
            if (win_vld) begin
              grant   = 1'b1;
              a_d     = win_a;
              d_d     = win_d;
              pay_a_d = win_a;
              pay_d_d = win_d;
              gid_d   = win_idx;
              ptr_d   = inc_mod(win_idx);
            end else begin
              a_d     = IDLE_A;
              d_d     = '0;
              state_d = S_IDLE;
            end
          end
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_c   = 1'b1;
          a_d     = IDLE_A;
          d_d     = '0;
          cnt_d   = '0;
          rep_d   = '0;
          ptr_d   = inc_mod(gid_q);
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= 1'b0;
      a_q     <= IDLE_A;
      d_q     <= '0;
      pay_a_q <= '0;
      pay_d_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= enc_sync_i;
      a_q     <= a_d;
      d_q     <= d_d;
      pay_a_q <= pay_a_d;
      pay_d_q <= pay_d_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

  // Trinary digit: bit1 set means float (F), otherwise bit0 is the driven level.
  for (genvar g = 0; g < 8; g++) begin : g_adig
    assign enc_A_o[g] = a_q[2*g+1] ? 1'bz : a_q[2*g];
  end

  assign enc_D_o          = d_q;
  assign busy_o           = (state_q != S_IDLE);
  assign grant_id_o       = gid_q;
  assign req_if.req_ready = (grant && !reset) ? (N_REQ'(1) << win_idx) : '0;
  assign done_o           = done_c & ~reset;
  assign timeout_err_o    = tmo_c & ~reset;

endmodule
